// File: rtl/vstructs_pkg.sv
// Shared vector-writeback types: FIFO entry layout, SEW limit and write-source select.
package vstructs;

    localparam int VS_DATA_WIDTH = 64;
    localparam logic [2:0] SEW_MAX = 3'd3;

    typedef struct packed {
        logic [4:0]               dest;
        logic [VS_DATA_WIDTH-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_LD   = 2'd1,
        SEL_FIFO = 2'd2,
        SEL_EX   = 2'd3
    } wb_sel_t;

    function automatic logic sew_legal(input logic [2:0] sew);
        return (sew <= SEW_MAX);
    endfunction

endpackage

// File: rtl/vwb_fifo.sv
// Exec-result holding FIFO; a push into a full FIFO is accepted only alongside a pop.
module vwb_fifo
    import vstructs::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  wb_entry_t                din,
    output wb_entry_t                dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_entry_t         mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Entry storage; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/vwb.sv
// Vector writeback: arbitrates load data, queued exec results and direct exec results onto one RF write port.
module vwb
    import vstructs::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ex_valid,
    input  logic [4:0]              ex_dest,
    input  logic [DATA_WIDTH-1:0]   ex_result,
    input  logic                    ex_masked,
    input  logic [DATA_WIDTH-1:0]   ex_old,
    input  logic [2:0]              ex_sew,
    input  logic                    ld_wait,
    input  logic [4:0]              ld_wait_dest,
    input  logic                    ld_valid,
    input  logic [4:0]              ld_dest,
    input  logic [DATA_WIDTH-1:0]   ld_data,
    input  logic [DATA_WIDTH/8-1:0] ld_be,
    output logic                    rf_we,
    output logic [4:0]              rf_addr,
    output logic [DATA_WIDTH-1:0]   rf_data,
    output logic [DATA_WIDTH/8-1:0] rf_be,
    output logic                    almost_full,
    output logic                    err_overflow,
    output logic                    err_sew
);
    localparam int BE_W = DATA_WIDTH / 8;
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;

    wb_entry_t             head_s;
    wb_entry_t             din_s;
    logic                  full_s;
    logic                  empty_s;
    logic [CW-1:0]         count_s;
    wb_sel_t               sel_s;
    logic                  ex_legal_s;
    logic [DATA_WIDTH-1:0] ex_data_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  ovf_s;
    logic [CW-1:0]         cnt_next_s;
    logic [4:0]            wr_addr_s;
    logic [DATA_WIDTH-1:0] wr_data_s;
    logic [BE_W-1:0]       wr_be_s;

    vwb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (din_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // Write-source selection: load, then FIFO head, then direct exec (only when nothing is queued).
    always_comb begin
        ex_legal_s   = ex_valid && sew_legal(ex_sew);
        ex_data_s    = ex_masked ? ex_old : ex_result;
        din_s.dest   = ex_dest;
        din_s.data   = VS_DATA_WIDTH'(ex_data_s);
        sel_s        = SEL_NONE;
        if (ld_valid) begin
            sel_s = SEL_LD;
        end else if (!empty_s && !(ld_wait && (head_s.dest == ld_wait_dest))) begin
            sel_s = SEL_FIFO;
        end else if (ex_legal_s && empty_s && !(ld_wait && (ex_dest == ld_wait_dest))) begin
            sel_s = SEL_EX;
        end else begin
            sel_s = SEL_NONE;
        end
        push_s     = ex_legal_s && (sel_s != SEL_EX);
        pop_s      = (sel_s == SEL_FIFO);
        ovf_s      = push_s && full_s && !pop_s;
        cnt_next_s = count_s + CW'(push_s && !ovf_s) - CW'(pop_s);
        case (sel_s)
            SEL_LD: begin
                wr_addr_s = ld_dest;
                wr_data_s = ld_data;
                wr_be_s   = ld_be;
            end
            SEL_FIFO: begin
                wr_addr_s = head_s.dest;
                wr_data_s = DATA_WIDTH'(head_s.data);
                wr_be_s   = {BE_W{1'b1}};
            end
            SEL_EX: begin
                wr_addr_s = ex_dest;
                wr_data_s = ex_data_s;
                wr_be_s   = {BE_W{1'b1}};
            end
            default: begin
                wr_addr_s = rf_addr;
                wr_data_s = rf_data;
                wr_be_s   = rf_be;
            end
        endcase
    end

    // RF port and status registers; address/data/enables hold on idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we        <= 1'b0;
            rf_addr      <= 5'd0;
            rf_data      <= {DATA_WIDTH{1'b0}};
            rf_be        <= {BE_W{1'b0}};
            almost_full  <= 1'b0;
            err_overflow <= 1'b0;
            err_sew      <= 1'b0;
        end else begin
            rf_we        <= (sel_s != SEL_NONE);
            rf_addr      <= wr_addr_s;
            rf_data      <= wr_data_s;
            rf_be        <= wr_be_s;
            almost_full  <= (cnt_next_s >= CW'(FIFO_DEPTH - 1));
            err_overflow <= err_overflow || ovf_s;
            err_sew      <= err_sew || (ex_valid && !sew_legal(ex_sew));
        end
    end

endmodule

// File: tb/tb_vwb.sv
// Directed plus randomized bench for vwb against a queue-based writeback reference model.
module tb_vwb;
    localparam int DW    = 64;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ex_valid;
    logic [4:0]    ex_dest;
    logic [DW-1:0] ex_result;
    logic          ex_masked;
    logic [DW-1:0] ex_old;
    logic [2:0]    ex_sew;
    logic          ld_wait;
    logic [4:0]    ld_wait_dest;
    logic          ld_valid;
    logic [4:0]    ld_dest;
    logic [DW-1:0] ld_data;
    logic [7:0]    ld_be;
    logic          rf_we;
    logic [4:0]    rf_addr;
    logic [DW-1:0] rf_data;
    logic [7:0]    rf_be;
    logic          almost_full;
    logic          err_overflow;
    logic          err_sew;

    vwb #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_dest(ex_dest), .ex_result(ex_result),
        .ex_masked(ex_masked), .ex_old(ex_old), .ex_sew(ex_sew),
        .ld_wait(ld_wait), .ld_wait_dest(ld_wait_dest),
        .ld_valid(ld_valid), .ld_dest(ld_dest), .ld_data(ld_data), .ld_be(ld_be),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .rf_be(rf_be),
        .almost_full(almost_full), .err_overflow(err_overflow), .err_sew(err_sew)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]    dest;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          q[$];
    logic          m_we;
    logic [4:0]    m_addr;
    logic [DW-1:0] m_data;
    logic [7:0]    m_be;
    logic          m_ovf;
    logic          m_sew;
    int            checks   = 0;
    int            failures = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_we = 1'b0; m_addr = 5'd0; m_data = '0; m_be = 8'd0;
        m_ovf = 1'b0; m_sew = 1'b0;
    endtask

    task automatic idle();
        ex_valid = 1'b0; ex_masked = 1'b0; ex_sew = 3'd0; ex_dest = 5'd0;
        ex_result = '0; ex_old = '0;
        ld_wait = 1'b0; ld_wait_dest = 5'd0;
        ld_valid = 1'b0; ld_dest = 5'd0; ld_data = '0; ld_be = 8'd0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".we"},   {63'd0, rf_we},        {63'd0, m_we});
        chk({tag, ".addr"}, {59'd0, rf_addr},      {59'd0, m_addr});
        chk({tag, ".data"}, rf_data,               m_data);
        chk({tag, ".be"},   {56'd0, rf_be},        {56'd0, m_be});
        chk({tag, ".af"},   {63'd0, almost_full},  {63'd0, (q.size() >= DEPTH - 1)});
        chk({tag, ".ovf"},  {63'd0, err_overflow}, {63'd0, m_ovf});
        chk({tag, ".sew"},  {63'd0, err_sew},      {63'd0, m_sew});
    endtask

    // Apply the writeback rules to the current inputs, clock once, then compare.
    task automatic step(input string tag);
        logic          direct;
        logic [DW-1:0] exd;
        ent_t          e;
        exd    = ex_masked ? ex_old : ex_result;
        direct = 1'b0;
        m_we   = 1'b0;
        if (ld_valid) begin
            m_we = 1'b1; m_addr = ld_dest; m_data = ld_data; m_be = ld_be;
        end else if (q.size() > 0 && !(ld_wait && q[0].dest == ld_wait_dest)) begin
            e = q.pop_front();
            m_we = 1'b1; m_addr = e.dest; m_data = e.data; m_be = 8'hFF;
        end else if (ex_valid && ex_sew <= 3'd3 && q.size() == 0 &&
                     !(ld_wait && ex_dest == ld_wait_dest)) begin
            direct = 1'b1;
            m_we = 1'b1; m_addr = ex_dest; m_data = exd; m_be = 8'hFF;
        end
        if (ex_valid) begin
            if (ex_sew > 3'd3) begin
                m_sew = 1'b1;
            end else if (!direct) begin
                if (q.size() < DEPTH) begin
                    e.dest = ex_dest; e.data = exd;
                    q.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Direct exec write
        ex_valid = 1'b1; ex_dest = 5'd3; ex_result = 64'hAA; ex_sew = 3'd3;
        step("direct");
        chk("direct.addr_const", {59'd0, rf_addr}, 64'd3);
        chk("direct.be_const", {56'd0, rf_be}, 64'hFF);

        // Masked element writes old value
        ex_masked = 1'b1; ex_old = 64'h55; ex_dest = 5'd7; ex_sew = 3'd0;
        step("masked");
        chk("masked.data_const", rf_data, 64'h55);

        // Load wins, exec follows next cycle
        idle();
        ld_valid = 1'b1; ld_dest = 5'd2; ld_data = 64'h11; ld_be = 8'h0F;
        ex_valid = 1'b1; ex_dest = 5'd4; ex_result = 64'h44;
        step("ldex.ld");
        idle();
        step("ldex.ex");
        chk("ldex.ex_addr_const", {59'd0, rf_addr}, 64'd4);

        // Exec stalled behind outstanding load to the same vreg
        ld_wait = 1'b1; ld_wait_dest = 5'd5;
        ex_valid = 1'b1; ex_dest = 5'd5; ex_result = 64'h505;
        step("wait.ex5");
        ex_dest = 5'd6; ex_result = 64'h606;
        step("wait.ex6");
        ex_valid = 1'b0;
        step("wait.hold0");
        step("wait.hold1");
        ld_valid = 1'b1; ld_dest = 5'd5; ld_data = 64'hDEAD; ld_be = 8'hFF; ld_wait = 1'b0;
        step("wait.ld5");
        idle();
        step("wait.q5");
        step("wait.q6");
        step("wait.empty");

        // Sustained loads fill the FIFO until overflow
        ld_valid = 1'b1; ld_be = 8'h01;
        for (int i = 0; i < 5; i++) begin
            ld_dest = 5'(i); ld_data = 64'(i + 100);
            ex_valid = 1'b1; ex_dest = 5'(10 + i); ex_result = 64'(i + 200);
            step($sformatf("ovf.push%0d", i));
            if (i == 2) chk("ovf.af_after3", {63'd0, almost_full}, 64'd1);
        end
        chk("ovf.flag_const", {63'd0, err_overflow}, 64'd1);
        idle();
        for (int i = 0; i < 5; i++) step($sformatf("ovf.drain%0d", i));

        // Reset with pending entries and a flagged SEW error
        ld_valid = 1'b1;
        ex_valid = 1'b1; ex_sew = 3'd5; ex_dest = 5'd9;
        step("rst.badsew");
        ex_sew = 3'd1;
        for (int i = 0; i < 3; i++) begin
            ex_dest = 5'(20 + i); ex_result = 64'(i + 300);
            step($sformatf("rst.fill%0d", i));
        end
        idle();
        ld_wait = 1'b1; ld_wait_dest = 5'd20;
        rst = 1'b1;
        #2;
        model_reset();
        check_all("rst.async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        for (int i = 0; i < 4; i++) step($sformatf("rst.after%0d", i));

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            ld_valid     = ($urandom % 4) == 0;
            ld_dest      = 5'($urandom_range(0, 31));
            ld_data      = {$urandom, $urandom};
            ld_be        = 8'($urandom);
            ld_wait      = ($urandom % 3) == 0;
            ld_wait_dest = 5'($urandom_range(0, 3));
            ex_valid     = ($urandom % 2) == 0;
            ex_dest      = 5'($urandom_range(0, 3));
            ex_result    = {$urandom, $urandom};
            ex_old       = {$urandom, $urandom};
            ex_masked    = ($urandom % 4) == 0;
            ex_sew       = (i > 300) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 3));
            step($sformatf("rand%0d", i));
        end
        idle();
        for (int i = 0; i < 6; i++) step($sformatf("rand.drain%0d", i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
